mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates the single-port PDP-8 main memory between the instruction fetch/decode unit (IFD) and the execution unit (EXEC).
- IFD issues instruction-fetch reads. EXEC issues operand reads and result writes.
- Sits between instr_decode/instr_exec and memory_pdp. Sequences each access through a fixed-latency FSM and enforces starvation-free priority.

Parameters:
ADDR_WIDTH, 12, memory address width (4K words)
DATA_WIDTH, 12, memory word width
MEM_LATENCY, 1, cycles from mem_rd_req high to mem_rd_data valid (1..3)
STARVE_LIMIT, 4, consecutive EXEC grants allowed while IFD is waiting (1..7)

Ports:
clk  in  1  free-running clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
ifd_rd_req  in  1  IFD fetch request (level, held until done)
ifd_rd_addr  in  ADDR_WIDTH  fetch address
ifd_rd_data  out  DATA_WIDTH  fetched word, valid with ifd_rd_done, held afterwards
ifd_rd_done  out  1  one-cycle completion pulse
exec_rd_req  in  1  EXEC operand read request (level)
exec_rd_addr  in  ADDR_WIDTH  operand address
exec_rd_data  out  DATA_WIDTH  operand word, valid with exec_rd_done, held afterwards
exec_rd_done  out  1  one-cycle completion pulse
exec_wr_req  in  1  EXEC write request (level)
exec_wr_addr  in  ADDR_WIDTH  write address
exec_wr_data  in  DATA_WIDTH  write data
exec_wr_done  out  1  one-cycle completion pulse
mem_rd_req  out  1  memory read strobe, one cycle
mem_rd_addr  out  ADDR_WIDTH  memory read address
mem_rd_data  in  DATA_WIDTH  memory read data
mem_wr_req  out  1  memory write strobe, one cycle
mem_wr_addr  out  ADDR_WIDTH  memory write address
mem_wr_data  out  DATA_WIDTH  memory write data

Behaviour:
- Reset (asynchronous, any state): all outputs 0; FSM to IDLE; starve counter 0. An in-flight access is dropped and no done is issued.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, DONE, RELEASE.
- IDLE: samples all requests each cycle. Winner's address/data are latched; later changes to inputs are ignored until done.
- Priority:
  - Normal order: exec_wr > exec_rd > ifd_rd.
  - Starvation override: if starve_cnt == STARVE_LIMIT and ifd_rd_req is high, IFD wins.
  - exec_rd_req and exec_wr_req both high: write wins; the read is served on a later arbitration.
- Starve counter: 3 bits. Increments on each EXEC grant while ifd_rd_req is high; saturates at STARVE_LIMIT. Cleared on any IFD grant and whenever IDLE sees ifd_rd_req low.
- Read, with IDLE sample in cycle 0:
  - Cycle 1: RD_ISSUE, mem_rd_req=1, mem_rd_addr=latched address.
  - RD_WAIT for MEM_LATENCY cycles; mem_rd_data is captured in cycle 1+MEM_LATENCY.
  - Cycle 2+MEM_LATENCY: DONE. Requester's done=1 and its data output is updated that same cycle.
  - Next cycle: RELEASE. Then IDLE.
  - With MEM_LATENCY=1: done in cycle 3, next sample in cycle 5.
- Write, with IDLE sample in cycle 0:
  - Cycle 1: WR_ISSUE, mem_wr_req=1 with latched address/data.
  - Cycle 2: DONE, exec_wr_done=1.
  - Cycle 3: RELEASE. Cycle 4: IDLE.
- RELEASE ignores all requests. A requester must deassert req in the cycle after its done. If req is still high at the next IDLE sample, it is a new request.
- mem_rd_addr, mem_wr_addr and mem_wr_data return to 0 outside their issue cycle.
- Never more than one of mem_rd_req/mem_wr_req high. Never more than one done high.
- A *_rd_data output changes only in its own DONE cycle or on reset.
- A request dropped before its grant is never served. A request dropped after its grant still completes, and the done pulse is issued.

Test Plan:
- Reset, then ifd_rd_req with addr 12'o200 and memory word 12'o7402 → mem_rd_req in cycle 1 with addr 12'o200; ifd_rd_done and ifd_rd_data=12'o7402 in cycle 3 (MEM_LATENCY=1).
- exec_wr_req (addr 12'o0050, data 12'o1234) together with ifd_rd_req → write issued first, exec_wr_done in cycle 2; IFD read starts at the cycle-4 IDLE sample.
- exec_rd_req held continuously plus ifd_rd_req held, STARVE_LIMIT=4 → exactly 4 EXEC reads complete, then 1 IFD read, then EXEC resumes.
- exec_rd_req and exec_wr_req both high to the same address 12'o0100 → write completes first; the read then returns the written data 12'o1234.
- reset_n pulsed low in RD_WAIT → all outputs 0 immediately; no done pulse; the next request is served normally from IDLE.
- MEM_LATENCY=3, IFD read → done in cycle 5; changing ifd_rd_addr after cycle 0 does not alter mem_rd_addr.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port PDP-8 memory arbiter between instruction fetch (IFD) and execute (EXEC).
// Each access runs through a fixed-latency sequence; the starve counter guarantees IFD progress.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 12,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ifd_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifd_rd_addr,
  output logic [DATA_WIDTH-1:0] ifd_rd_data,
  output logic                  ifd_rd_done,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_done,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_done,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data
);

  localparam int unsigned STARVE_W = 3;
  localparam int unsigned WAIT_W   = 2;
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [WAIT_W-1:0]   WAIT_INIT  = WAIT_W'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_WAIT,
    WR_ISSUE,
    DONE,
    RELEASE
  } state_t;

  state_t              state;
  logic [STARVE_W-1:0] starve_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                rd_for_ifd;

  logic starve_hit;
  logic wr_win;
  logic rd_win;
  logic ifd_win;

  // Arbitration: write > operand read > fetch, unless IFD has been starved long enough.
  always_comb begin
    starve_hit = 1'b0;
    wr_win     = 1'b0;
    rd_win     = 1'b0;
    ifd_win    = 1'b0;
    starve_hit = ifd_rd_req && (starve_cnt == STARVE_MAX);
    wr_win     = exec_wr_req && !starve_hit;
    rd_win     = exec_rd_req && !exec_wr_req && !starve_hit;
    ifd_win    = ifd_rd_req && (starve_hit || (!exec_wr_req && !exec_rd_req));
  end

  // The issue-cycle output registers double as the latched winner address/data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      starve_cnt   <= '0;
      wait_cnt     <= '0;
      rd_for_ifd   <= 1'b0;
      ifd_rd_data  <= '0;
      ifd_rd_done  <= 1'b0;
      exec_rd_data <= '0;
      exec_rd_done <= 1'b0;
      exec_wr_done <= 1'b0;
      mem_rd_req   <= 1'b0;
      mem_rd_addr  <= '0;
      mem_wr_req   <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;
    end else begin
      ifd_rd_done  <= 1'b0;
      exec_rd_done <= 1'b0;
      exec_wr_done <= 1'b0;
      mem_rd_req   <= 1'b0;
      mem_rd_addr  <= '0;
      mem_wr_req   <= 1'b0;
      mem_wr_addr  <= '0;
      mem_wr_data  <= '0;

      case (state)
        IDLE: begin
          if (!ifd_rd_req) begin
            starve_cnt <= '0;
          end
          if (wr_win) begin
            state       <= WR_ISSUE;
            mem_wr_req  <= 1'b1;
            mem_wr_addr <= exec_wr_addr;
            mem_wr_data <= exec_wr_data;
            if (ifd_rd_req && (starve_cnt < STARVE_MAX)) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end else if (rd_win) begin
            state       <= RD_ISSUE;
            rd_for_ifd  <= 1'b0;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= exec_rd_addr;
            if (ifd_rd_req && (starve_cnt < STARVE_MAX)) begin
              starve_cnt <= starve_cnt + STARVE_W'(1);
            end
          end else if (ifd_win) begin
            state       <= RD_ISSUE;
            rd_for_ifd  <= 1'b1;
            mem_rd_req  <= 1'b1;
            mem_rd_addr <= ifd_rd_addr;
            starve_cnt  <= '0;
          end
        end
        RD_ISSUE: begin
          wait_cnt <= WAIT_INIT;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == '0) begin
            state <= DONE;
            if (rd_for_ifd) begin
              ifd_rd_done <= 1'b1;
              ifd_rd_data <= mem_rd_data;
            end else begin
              exec_rd_done <= 1'b1;
              exec_rd_data <= mem_rd_data;
            end
          end else begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end
        end
        WR_ISSUE: begin
          state        <= DONE;
          exec_wr_done <= 1'b1;
        end
        DONE:    state <= RELEASE;
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Bus-exclusivity invariants.
  a_one_strobe: assert property (@(posedge clk) disable iff (!reset_n)
    !(mem_rd_req && mem_wr_req));
  a_one_done: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0({ifd_rd_done, exec_rd_done, exec_wr_done}));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: dut 0 uses MEM_LATENCY=1, dut 1 uses MEM_LATENCY=3.
module tb_mem_arbiter;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 12;

  typedef enum int {EV_RD, EV_WR, EV_IFD_DONE, EV_ERD_DONE, EV_WR_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t      kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic          ifd_rd_req [2];
  logic [AW-1:0] ifd_rd_addr [2];
  logic [DW-1:0] ifd_rd_data [2];
  logic          ifd_rd_done [2];
  logic          exec_rd_req [2];
  logic [AW-1:0] exec_rd_addr [2];
  logic [DW-1:0] exec_rd_data [2];
  logic          exec_rd_done [2];
  logic          exec_wr_req [2];
  logic [AW-1:0] exec_wr_addr [2];
  logic [DW-1:0] exec_wr_data [2];
  logic          exec_wr_done [2];
  logic          mem_rd_req [2];
  logic [AW-1:0] mem_rd_addr [2];
  logic [DW-1:0] mem_rd_data [2];
  logic          mem_wr_req [2];
  logic [AW-1:0] mem_wr_addr [2];
  logic [DW-1:0] mem_wr_data [2];

  exp_t sbq0[$];
  exp_t sbq1[$];
  logic [DW-1:0] hold_i [2];
  logic [DW-1:0] hold_e [2];

  logic [DW-1:0] mem [4096];
  logic [DW-1:0] p0, p1a, p1b, p1c;

  mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .ifd_rd_req(ifd_rd_req[0]), .ifd_rd_addr(ifd_rd_addr[0]),
    .ifd_rd_data(ifd_rd_data[0]), .ifd_rd_done(ifd_rd_done[0]),
    .exec_rd_req(exec_rd_req[0]), .exec_rd_addr(exec_rd_addr[0]),
    .exec_rd_data(exec_rd_data[0]), .exec_rd_done(exec_rd_done[0]),
    .exec_wr_req(exec_wr_req[0]), .exec_wr_addr(exec_wr_addr[0]),
    .exec_wr_data(exec_wr_data[0]), .exec_wr_done(exec_wr_done[0]),
    .mem_rd_req(mem_rd_req[0]), .mem_rd_addr(mem_rd_addr[0]), .mem_rd_data(mem_rd_data[0]),
    .mem_wr_req(mem_wr_req[0]), .mem_wr_addr(mem_wr_addr[0]), .mem_wr_data(mem_wr_data[0])
  );

  mem_arbiter #(.MEM_LATENCY(3), .STARVE_LIMIT(4)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .ifd_rd_req(ifd_rd_req[1]), .ifd_rd_addr(ifd_rd_addr[1]),
    .ifd_rd_data(ifd_rd_data[1]), .ifd_rd_done(ifd_rd_done[1]),
    .exec_rd_req(exec_rd_req[1]), .exec_rd_addr(exec_rd_addr[1]),
    .exec_rd_data(exec_rd_data[1]), .exec_rd_done(exec_rd_done[1]),
    .exec_wr_req(exec_wr_req[1]), .exec_wr_addr(exec_wr_addr[1]),
    .exec_wr_data(exec_wr_data[1]), .exec_wr_done(exec_wr_done[1]),
    .mem_rd_req(mem_rd_req[1]), .mem_rd_addr(mem_rd_addr[1]), .mem_rd_data(mem_rd_data[1]),
    .mem_wr_req(mem_wr_req[1]), .mem_wr_addr(mem_wr_addr[1]), .mem_wr_data(mem_wr_data[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: read data appears MEM_LATENCY edges after the strobe, stale otherwise.
  always @(posedge clk) begin
    if (mem_wr_req[0]) mem[mem_wr_addr[0]] <= mem_wr_data[0];
    p0  <= mem[mem_rd_addr[0]];
    p1a <= mem[mem_rd_addr[1]];
    p1b <= p1a;
    p1c <= p1b;
  end
  assign mem_rd_data[0] = p0;
  assign mem_rd_data[1] = p1c;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 'o%0o, expected 'o%0o", nm, cyc, got, exp);
    end
  endtask

  task automatic push(input int d, input ev_kind_t k, input logic [AW-1:0] a,
                      input logic [DW-1:0] dat, input int c);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.data = dat;
    e.cyc  = c;
    if (d == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic match(input int d, input ev_kind_t k, input logic [AW-1:0] ga,
                       input logic [DW-1:0] gd, input bit cmp_a, input bit cmp_d,
                       input string nm, output logic [DW-1:0] exp_data);
    exp_t e;
    int   sz;
    exp_data = '0;
    sz = (d == 0) ? sbq0.size() : sbq1.size();
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL %s dut%0d at cycle %0d: unexpected event, scoreboard empty", nm, d, cyc);
      return;
    end
    if (d == 0) e = sbq0.pop_front();
    else        e = sbq1.pop_front();
    chk({nm, "_kind"}, 32'(e.kind), 32'(k));
    chk({nm, "_cycle"}, 32'(cyc), 32'(e.cyc));
    if (cmp_a) chk({nm, "_addr"}, 32'(ga), 32'(e.addr));
    if (cmp_d) chk({nm, "_data"}, 32'(gd), 32'(e.data));
    exp_data = e.data;
  endtask

  task automatic mon(input int d);
    int n;
    logic [DW-1:0] x;
    if (!reset_n) begin
      hold_i[d] = '0;
      hold_e[d] = '0;
      return;
    end
    n = int'(mem_rd_req[d]) + int'(mem_wr_req[d]) + int'(ifd_rd_done[d])
      + int'(exec_rd_done[d]) + int'(exec_wr_done[d]);
    if (n > 0) chk("single_event", 32'(n), 32'd1);
    if (mem_rd_req[d]) match(d, EV_RD, mem_rd_addr[d], '0, 1'b1, 1'b0, "mem_rd", x);
    else chk("rd_addr_idle", 32'(mem_rd_addr[d]), 32'd0);
    if (mem_wr_req[d]) match(d, EV_WR, mem_wr_addr[d], mem_wr_data[d], 1'b1, 1'b1, "mem_wr", x);
    else chk("wr_bus_idle", 32'({mem_wr_addr[d], mem_wr_data[d]}), 32'd0);
    if (ifd_rd_done[d]) begin
      match(d, EV_IFD_DONE, '0, ifd_rd_data[d], 1'b0, 1'b1, "ifd_done", x);
      hold_i[d] = x;
    end else chk("ifd_data_hold", 32'(ifd_rd_data[d]), 32'(hold_i[d]));
    if (exec_rd_done[d]) begin
      match(d, EV_ERD_DONE, '0, exec_rd_data[d], 1'b0, 1'b1, "exec_rd_done", x);
      hold_e[d] = x;
    end else chk("exec_data_hold", 32'(exec_rd_data[d]), 32'(hold_e[d]));
    if (exec_wr_done[d]) match(d, EV_WR_DONE, '0, '0, 1'b0, 1'b0, "wr_done", x);
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  function automatic bit outs_zero(input int d);
    return (ifd_rd_data[d] == '0) && !ifd_rd_done[d] && (exec_rd_data[d] == '0)
        && !exec_rd_done[d] && !exec_wr_done[d] && !mem_rd_req[d] && (mem_rd_addr[d] == '0)
        && !mem_wr_req[d] && (mem_wr_addr[d] == '0) && (mem_wr_data[d] == '0);
  endfunction

  // which: 0 ifd_rd_done, 1 exec_rd_done, 2 exec_wr_done
  task automatic wait_done(input int d, input int which, input int maxc, input string nm);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      case (which)
        0:       seen = ifd_rd_done[d];
        1:       seen = exec_rd_done[d];
        default: seen = exec_wr_done[d];
      endcase
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: no done pulse within %0d cycles", nm, maxc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'o0000] = 12'o5555;
    mem[12'o0100] = 12'o0007;
    mem[12'o0200] = 12'o7402;
    mem[12'o0300] = 12'o1111;
    mem[12'o0400] = 12'o2222;
    for (int d = 0; d < 2; d++) begin
      ifd_rd_req[d] = 1'b0;  ifd_rd_addr[d] = '0;
      exec_rd_req[d] = 1'b0; exec_rd_addr[d] = '0;
      exec_wr_req[d] = 1'b0; exec_wr_addr[d] = '0; exec_wr_data[d] = '0;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs_dut0", 32'(outs_zero(0)), 32'd1);
    chk("reset_outs_dut1", 32'(outs_zero(1)), 32'd1);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Plain IFD fetch
    b = cyc;
    ifd_rd_addr[0] = 12'o0200; ifd_rd_req[0] = 1'b1;
    push(0, EV_RD, 12'o0200, '0, b + 1);
    push(0, EV_IFD_DONE, '0, 12'o7402, b + 3);
    wait_done(0, 0, 10, "t1_ifd");
    ifd_rd_req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Write beats a simultaneous fetch
    b = cyc;
    exec_wr_addr[0] = 12'o0050; exec_wr_data[0] = 12'o1234; exec_wr_req[0] = 1'b1;
    ifd_rd_addr[0] = 12'o0200; ifd_rd_req[0] = 1'b1;
    push(0, EV_WR, 12'o0050, 12'o1234, b + 1);
    push(0, EV_WR_DONE, '0, '0, b + 2);
    push(0, EV_RD, 12'o0200, '0, b + 5);
    push(0, EV_IFD_DONE, '0, 12'o7402, b + 7);
    wait_done(0, 2, 10, "t2_wr");
    exec_wr_req[0] = 1'b0;
    wait_done(0, 0, 10, "t2_ifd");
    ifd_rd_req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Starvation: four EXEC reads, one IFD read, EXEC again
    b = cyc;
    exec_rd_addr[0] = 12'o0300; exec_rd_req[0] = 1'b1;
    ifd_rd_addr[0] = 12'o0200; ifd_rd_req[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(0, EV_RD, 12'o0300, '0, b + 5*k + 1);
      push(0, EV_ERD_DONE, '0, 12'o1111, b + 5*k + 3);
    end
    push(0, EV_RD, 12'o0200, '0, b + 21);
    push(0, EV_IFD_DONE, '0, 12'o7402, b + 23);
    push(0, EV_RD, 12'o0300, '0, b + 26);
    push(0, EV_ERD_DONE, '0, 12'o1111, b + 28);
    wait_done(0, 0, 40, "t3_ifd");
    ifd_rd_req[0] = 1'b0;
    wait_done(0, 1, 10, "t3_exec");
    exec_rd_req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Read and write to the same address: write first, read sees new data
    b = cyc;
    exec_wr_addr[0] = 12'o0100; exec_wr_data[0] = 12'o1234; exec_wr_req[0] = 1'b1;
    exec_rd_addr[0] = 12'o0100; exec_rd_req[0] = 1'b1;
    push(0, EV_WR, 12'o0100, 12'o1234, b + 1);
    push(0, EV_WR_DONE, '0, '0, b + 2);
    push(0, EV_RD, 12'o0100, '0, b + 5);
    push(0, EV_ERD_DONE, '0, 12'o1234, b + 7);
    wait_done(0, 2, 10, "t4_wr");
    exec_wr_req[0] = 1'b0;
    wait_done(0, 1, 10, "t4_rd");
    exec_rd_req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Write dropped after grant completes; read dropped before grant is never served
    b = cyc;
    exec_wr_addr[0] = 12'o0060; exec_wr_data[0] = 12'o4321; exec_wr_req[0] = 1'b1;
    push(0, EV_WR, 12'o0060, 12'o4321, b + 1);
    push(0, EV_WR_DONE, '0, '0, b + 2);
    @(negedge clk);
    exec_wr_req[0] = 1'b0;
    exec_rd_addr[0] = 12'o0300; exec_rd_req[0] = 1'b1;
    wait_done(0, 2, 5, "t7_wr");
    exec_rd_req[0] = 1'b0;
    repeat (5) @(negedge clk);

    // Reset during RD_WAIT drops the access
    b = cyc;
    ifd_rd_addr[0] = 12'o0400; ifd_rd_req[0] = 1'b1;
    push(0, EV_RD, 12'o0400, '0, b + 1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    ifd_rd_req[0] = 1'b0;
    #1;
    chk("midreset_outs", 32'(outs_zero(0)), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    b = cyc;
    ifd_rd_req[0] = 1'b1;
    push(0, EV_RD, 12'o0400, '0, b + 1);
    push(0, EV_IFD_DONE, '0, 12'o2222, b + 3);
    wait_done(0, 0, 10, "t5_ifd");
    ifd_rd_req[0] = 1'b0;
    repeat (3) @(negedge clk);

    // Latency 3; address change after grant is ignored
    b = cyc;
    ifd_rd_addr[1] = 12'o0200; ifd_rd_req[1] = 1'b1;
    push(1, EV_RD, 12'o0200, '0, b + 1);
    push(1, EV_IFD_DONE, '0, 12'o7402, b + 5);
    @(negedge clk);
    ifd_rd_addr[1] = 12'o0777;
    wait_done(1, 0, 10, "t6_ifd");
    ifd_rd_req[1] = 1'b0;
    repeat (5) @(negedge clk);

    chk("sb0_empty", 32'(sbq0.size()), 32'd0);
    chk("sb1_empty", 32'(sbq1.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
